// File: rtl/feature_write_ctrl.sv
// Stream words -> registered feature-buffer write strobes one cycle after each handshake; s_ready high only in WRITE.
// FEATURE_WRITE_PINGPONG_EN enables multi-tile jobs alternating banks with per-bank busy flags.
module feature_write_ctrl #(
  parameter int FEATURE_WIDTH = 16,
  parameter int ADDR_WIDTH    = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [ADDR_WIDTH-1:0]      cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]      cfg_len,
  input  logic [7:0]                 cfg_tiles,
  input  logic                       cfg_bank,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [2*FEATURE_WIDTH-1:0] s_data,
  input  logic [1:0]                 bank_release,
  output logic                       fetcher_to_mem,
  output logic [ADDR_WIDTH-1:0]      wr_feature_addr,
  output logic [2*FEATURE_WIDTH-1:0] wr_feature_data,
  output logic                       wr_feature_sel,
  output logic [1:0]                 bank_busy,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, WAIT_BANK, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      base_q, base_d;
  logic [ADDR_WIDTH-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0]      word_cnt_q, word_cnt_d;
  logic [7:0]                 tiles_q, tiles_d;
  logic [7:0]                 tile_cnt_q, tile_cnt_d;
  logic                       cur_bank_q, cur_bank_d;
  logic [1:0]                 bank_busy_q, bank_busy_d;
  logic                       strb_q, strb_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [2*FEATURE_WIDTH-1:0] data_q, data_d;
  logic                       sel_q, sel_d;
  logic                       hs;
  logic                       tile_end;

`ifndef FEATURE_WRITE_PINGPONG_EN
  logic unused_ok;
  assign unused_ok = ^{cfg_tiles, bank_release};
`endif

  assign s_ready  = (state_q == WRITE);
  assign hs       = s_valid && s_ready;
  assign tile_end = hs && (word_cnt_q == len_q - ONE);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    tiles_d     = tiles_q;
    tile_cnt_d  = tile_cnt_q;
    cur_bank_d  = cur_bank_q;
    strb_d      = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
`ifdef FEATURE_WRITE_PINGPONG_EN
    bank_busy_d = bank_busy_q & ~bank_release;
`else
    bank_busy_d = 2'b00;
`endif

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          base_d     = cfg_base_addr;
          len_d      = (cfg_len == '0) ? ONE : cfg_len;
`ifdef FEATURE_WRITE_PINGPONG_EN
          tiles_d    = (cfg_tiles == 8'd0) ? 8'd1 : cfg_tiles;
`else
          tiles_d    = 8'd1;
`endif
          word_cnt_d = '0;
          tile_cnt_d = 8'd0;
          cur_bank_d = cfg_bank;
          state_d    = WAIT_BANK;
        end
      end
      WAIT_BANK: begin
        if (!bank_busy_q[cur_bank_q]) state_d = WRITE;
      end
      WRITE: begin
        if (hs) begin
          strb_d     = 1'b1;
          addr_d     = base_q + word_cnt_q;
          data_d     = s_data;
          sel_d      = cur_bank_q;
          word_cnt_d = word_cnt_q + ONE;
        end
        // Set after the release mask so a same-cycle release loses.
        if (tile_end) begin
          word_cnt_d = '0;
`ifdef FEATURE_WRITE_PINGPONG_EN
          bank_busy_d[cur_bank_q] = 1'b1;
`endif
          if (tile_cnt_q == tiles_q - 8'd1) begin
            state_d = DONE;
          end else begin
            tile_cnt_d = tile_cnt_q + 8'd1;
`ifdef FEATURE_WRITE_PINGPONG_EN
            cur_bank_d = ~cur_bank_q;
`endif
            state_d    = WAIT_BANK;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      tiles_q     <= 8'd0;
      tile_cnt_q  <= 8'd0;
      cur_bank_q  <= 1'b0;
      bank_busy_q <= 2'b00;
      strb_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      tiles_q     <= tiles_d;
      tile_cnt_q  <= tile_cnt_d;
      cur_bank_q  <= cur_bank_d;
      bank_busy_q <= bank_busy_d;
      strb_q      <= strb_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
    end
  end

  assign fetcher_to_mem  = strb_q;
  assign wr_feature_addr = addr_q;
  assign wr_feature_data = data_q;
  assign wr_feature_sel  = sel_q;
  assign bank_busy       = bank_busy_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_feature_write_ctrl.sv
// Scoreboard bench for feature_write_ctrl: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_feature_write_ctrl;
  localparam int FW = 16;
  localparam int AW = 15;
`ifdef FEATURE_WRITE_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [2*FW-1:0] data;
    logic            sel;
    logic            dn;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_start = 1'b0;
  logic [AW-1:0]   cfg_base_addr = '0;
  logic [AW-1:0]   cfg_len = '0;
  logic [7:0]      cfg_tiles = 8'd0;
  logic            cfg_bank = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [2*FW-1:0] s_data = '0;
  logic [1:0]      bank_release = 2'b00;
  logic            fetcher_to_mem;
  logic [AW-1:0]   wr_feature_addr;
  logic [2*FW-1:0] wr_feature_data;
  logic            wr_feature_sel;
  logic [1:0]      bank_busy;
  logic            busy;
  logic            done;

  int   checks = 0;
  int   errors = 0;
  int   job_id = 1;
  exp_t exp_q[$];
  logic hs_prev = 1'b0;
  int   gap_tab[8] = '{0, 2, 1, 0, 3, 1, 0, 2};

  feature_write_ctrl #(.FEATURE_WIDTH(FW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_len(cfg_len), .cfg_tiles(cfg_tiles), .cfg_bank(cfg_bank),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .bank_release(bank_release),
    .fetcher_to_mem(fetcher_to_mem), .wr_feature_addr(wr_feature_addr),
    .wr_feature_data(wr_feature_data), .wr_feature_sel(wr_feature_sel),
    .bank_busy(bank_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops one expected write; strobes must follow handshakes by exactly one cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (fetcher_to_mem === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: addr 0x%0h data 0x%0h", wr_feature_addr, wr_feature_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_feature_addr, wr_feature_data, wr_feature_sel, done} !== e) begin
          errors++;
          $display("FAIL write: got addr 0x%0h data 0x%0h sel %0b done %0b expected addr 0x%0h data 0x%0h sel %0b done %0b",
                   wr_feature_addr, wr_feature_data, wr_feature_sel, done, e.addr, e.data, e.sel, e.dn);
        end
      end
    end else if (done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_without_strobe: got done 1 expected 0");
    end
    if (hs_prev || fetcher_to_mem === 1'b1) begin
      checks++;
      if (fetcher_to_mem !== hs_prev) begin
        errors++;
        $display("FAIL strobe_latency: got strobe %0b expected %0b", fetcher_to_mem, hs_prev);
      end
    end
    hs_prev = s_valid && s_ready && rst;
  end

  task automatic drive_word(input logic [AW-1:0] a, input logic [2*FW-1:0] d, input logic sel,
                            input logic dn, input int gap, input logic [1:0] rel);
    exp_t e;
    bit   got;
    int   n;
    e.addr = a; e.data = d; e.sel = sel; e.dn = dn;
    exp_q.push_back(e);
    got = 1'b0;
    n = 0;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = d;
    while (!got && n < 300) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        got = 1'b1;
        if (rel != 2'b00) bank_release = rel;
      end
      @(posedge clk); #1;
      if (got && rel != 2'b00) bank_release = 2'b00;
      n++;
    end
    s_valid = 1'b0;
    s_data  = 32'hDEAD_BEEF;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got no s_ready expected handshake for addr 0x%0h", a);
    end
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic [7:0] tiles, input logic bank);
    cfg_base_addr = base; cfg_len = len; cfg_tiles = tiles; cfg_bank = bank;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_base_addr = '1; cfg_len = '1; cfg_tiles = 8'hFF; cfg_bank = ~bank;
    @(negedge clk);
    chk("start_s_ready_low", s_ready, 0);
    chk("start_busy", busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("job_idle_in_time", (n < 100), 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic release_all();
    bank_release = 2'b11;
    @(posedge clk); #1;
    bank_release = 2'b00;
    @(negedge clk);
    chk("release_all", bank_busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic [7:0] tiles,
                         input logic bank, input bit gaps, input bit collide);
    int            nt, nl, g;
    logic          b, last;
    logic [AW-1:0] a;
    logic [1:0]    rel;
    nl = (len == '0) ? 1 : int'(len);
    nt = (!PP || tiles == 8'd0) ? 1 : int'(tiles);
    start_job(base, len, tiles, bank);
    for (int t = 0; t < nt; t++) begin
      b = PP ? (bank ^ t[0]) : bank;
      for (int i = 0; i < nl; i++) begin
        a    = base + AW'(i);
        last = (t == nt - 1) && (i == nl - 1);
        g    = gaps ? gap_tab[(t * nl + i) % 8] : 0;
        rel  = (last && collide) ? (b ? 2'b10 : 2'b01) : 2'b00;
        drive_word(a, {8'(job_id), 8'(t), 16'(i)}, b, last, g, rel);
      end
    end
    wait_idle();
    job_id++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b0; s_valid = 1'b1; s_data = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_strobe", fetcher_to_mem, 0);
      chk("rst_addr", wr_feature_addr, 0);
      chk("rst_data", wr_feature_data, 0);
      chk("rst_sel", wr_feature_sel, 0);
      chk("rst_bank_busy", bank_busy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;

    run_job(15'h0100, 15'd4, 8'd1, 1'b1, 1'b0, 1'b0);
    chk("single_bank_busy", bank_busy, PP ? 2'b10 : 2'b00);
    release_all();

    fork
      run_job(15'h0040, 15'd2, 8'd3, 1'b0, 1'b0, 1'b0);
`ifdef FEATURE_WRITE_PINGPONG_EN
      begin : stall_thread
        int n;
        n = 0;
        while (bank_busy !== 2'b11 && n < 200) begin @(negedge clk); n++; end
        chk("stall_reached", (n < 200), 1);
        repeat (4) begin
          @(negedge clk);
          chk("stall_s_ready", s_ready, 0);
          chk("stall_busy", busy, 1);
        end
        @(posedge clk); #1;
        cfg_base_addr = 15'h0555; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("stall_ignores_start", s_ready, 0);
        @(posedge clk); #1;
        bank_release = 2'b01;
        @(posedge clk); #1;
        bank_release = 2'b00;
      end
`endif
    join
    chk("pingpong_bank_busy", bank_busy, PP ? 2'b11 : 2'b00);
    release_all();

    run_job(15'h7FFE, 15'd4, 8'd1, 1'b0, 1'b0, 1'b0);
    chk("wrap_bank_busy", bank_busy, PP ? 2'b01 : 2'b00);
    release_all();

    run_job(15'h0010, 15'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("zero_cfg_bank_busy", bank_busy, PP ? 2'b01 : 2'b00);
    release_all();

    run_job(15'h0200, 15'd6, 8'd2, 1'b1, 1'b1, 1'b1);
    chk("collision_bank_busy", bank_busy, PP ? 2'b11 : 2'b00);

    start_job(15'h0300, 15'd5, 8'd1, 1'b0);
    drive_word(15'h0300, 32'hAB00_0000, 1'b0, 1'b0, 0, 2'b00);
    drive_word(15'h0301, 32'hAB00_0001, 1'b0, 1'b0, 0, 2'b00);
    rst = 1'b0; s_valid = 1'b1; s_data = 32'hAB00_0002;
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_strobe", fetcher_to_mem, 0);
      chk("abort_bank_busy", bank_busy, 0);
      chk("abort_busy", busy, 0);
      chk("abort_s_ready", s_ready, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1; s_valid = 1'b0;
    chk("abort_scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    run_job(15'h0400, 15'd3, 8'd1, 1'b1, 1'b0, 1'b0);
    chk("post_abort_bank_busy", bank_busy, PP ? 2'b10 : 2'b00);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
